// File: rtl/instr_prefetch.sv
// instr_prefetch: fetch-side front end.
// Owns the fetch PC, issues one req/ack read at a time to instruction memory and
// buffers returned bytes, tagged with their PCs, in a small FIFO that feeds decode.
// A redirect from execute flushes the FIFO and restarts fetch at the new PC. A read
// already in flight when a redirect arrives is completed and its data thrown away.
//
// Build option: define FETCH_STATS_EN to add the retired_cnt / flush_cnt ports.
//
// state | meaning
// IDLE  | no read outstanding; waiting for FIFO room
// REQ   | read of fetch_pc outstanding; its ack pushes into the FIFO
// DROP  | read of a pre-redirect address outstanding; its data is discarded
module instr_prefetch #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]       retired_cnt,
  output logic [7:0]        flush_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   drop_addr_q, drop_addr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   pc_mem_q   [DEPTH];
  logic [ADDR_W-1:0]   pc_mem_d   [DEPTH];
  logic [DATA_W-1:0]   data_mem_q [DEPTH];
  logic [DATA_W-1:0]   data_mem_d [DEPTH];

  logic                head_valid;
  logic                ack_req;
  logic                push_raw;
  logic                pop_raw;
  logic                push_en;
  logic                pop_en;
  logic [CNT_W-1:0]    occ_next;
  logic                room;

  // FIFO handshake terms; a redirect cancels both the push and the pop of its cycle
  always_comb begin
    head_valid = (count_q != '0);
    ack_req    = mem_ack && (state_q == ST_REQ);
    push_raw   = ack_req;
    pop_raw    = head_valid && instr_ready;
    push_en    = push_raw && !redirect_valid;
    pop_en     = pop_raw && !redirect_valid;
    occ_next   = count_q + CNT_W'(push_raw) - CNT_W'(pop_raw);
    room       = (occ_next < CNT_W'(DEPTH));
  end

  // fetch FSM: next state, fetch PC and the address latched for a dropped read
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      unique case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (mem_ack) begin
            state_d = ST_REQ;
          end else begin
            state_d     = ST_DROP;
            drop_addr_d = fetch_pc_q;
          end
        end
        ST_DROP: state_d = ST_DROP;
        default: state_d = ST_IDLE;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (room) state_d = ST_REQ;
        end
        ST_REQ: begin
          if (mem_ack) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            state_d    = room ? ST_REQ : ST_IDLE;
          end
        end
        ST_DROP: begin
          if (mem_ack) state_d = ST_REQ;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and storage update
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    data_mem_d = data_mem_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        pc_mem_d[wr_ptr_q]   = fetch_pc_q;
        data_mem_d[wr_ptr_q] = mem_rdata;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = occ_next;
    end
  end

  // control and pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed
  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    data_mem_q <= data_mem_d;
  end

  // memory side and decode side outputs
  always_comb begin
    mem_req     = (state_q != ST_IDLE);
    mem_addr    = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;
    instr_valid = head_valid;
    instr       = head_valid ? data_mem_q[rd_ptr_q] : '0;
    instr_pc    = head_valid ? pc_mem_q[rd_ptr_q] : '0;
  end

  // room is reserved before each read, so a push into a full FIFO is a design bug
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push_en && (count_q == CNT_W'(DEPTH))));

`ifdef FETCH_STATS_EN
  logic [15:0] retired_cnt_q, retired_cnt_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;

  // saturating event counters
  always_comb begin
    retired_cnt_d = retired_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    if (pop_en && (retired_cnt_q != 16'hFFFF)) retired_cnt_d = retired_cnt_q + 16'd1;
    if (redirect_valid && (flush_cnt_q != 8'hFF)) flush_cnt_d = flush_cnt_q + 8'd1;
  end

  // statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt_q <= '0;
      flush_cnt_q   <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign flush_cnt   = flush_cnt_q;
`else
  // Statistics build option disabled: no counters or ports exist.
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Testbench for instr_prefetch: directed scenarios followed by a randomized run
// against a stream-level reference model (expected PC sequence, data as a
// function of address, redirect/drop address rules).
module tb_instr_prefetch;

  logic       clk;
  logic       reset;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       instr_valid;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_ready;
`ifdef FETCH_STATS_EN
  logic [15:0] retired_cnt;
  logic [7:0]  flush_cnt;
`endif

  int n_vec;
  int n_err;

  instr_prefetch dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef FETCH_STATS_EN
    ,
    .retired_cnt    (retired_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // memory contents: a bijection of the address, so stale data is always detectable
  function automatic logic [7:0] mem_fn(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // memory answers the current request in the same cycle when ack_en is set
  task automatic set_mem(input bit ack_en);
    mem_ack   = mem_req && ack_en;
    mem_rdata = mem_ack ? mem_fn(mem_addr) : 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req"},   mem_req, 0);
    check_val({tag, "_addr"},  mem_addr, 0);
    check_val({tag, "_valid"}, instr_valid, 0);
    check_val({tag, "_instr"}, instr, 0);
    check_val({tag, "_pc"},    instr_pc, 0);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    instr_ready    = 1'b0;
    mem_ack        = 1'b0;
    mem_rdata      = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    set_mem(1'b1);
  endtask

  initial begin
    int  n_ack;
    bit  found;
    // random-phase model state
    logic [7:0] exp_pc;
    logic [7:0] want_target;
    logic [7:0] exp_addr;
    logic [7:0] prev_addr;
    bit  exp_addr_vld;
    bit  dropping;
    bit  nd;
    bit  prev_req;
    bit  prev_ack;
    bit  prev_redir;
    int  pops;
    int  redirs;

    n_vec = 0;
    n_err = 0;

    // 1: reset release, immediate acks, ready=1
    do_reset();
    instr_ready = 1'b1;
    @(negedge clk);
    check_val("t1_req", mem_req, 1);
    check_val("t1_addr", mem_addr, 8'h00);
    set_mem(1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("t1_valid", instr_valid, 1);
      check_val("t1_pc", instr_pc, i);
      check_val("t1_instr", instr, mem_fn(8'(i)));
      set_mem(1'b1);
    end

    // 2: ready=0, immediate acks fill the FIFO then fetch stops
    do_reset();
    n_ack = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_mem(1'b1);
      if (mem_ack) n_ack++;
    end
    check_val("t2_acks", n_ack, 4);
    check_val("t2_req_off", mem_req, 0);
    check_val("t2_head_pc", instr_pc, 8'h00);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check_val("t2_req_on", mem_req, 1);
    check_val("t2_addr", mem_addr, 8'h04);
    check_val("t2_head_pc2", instr_pc, 8'h01);
    set_mem(1'b1);
    @(negedge clk);
    check_val("t2_req_full", mem_req, 0);
    set_mem(1'b1);

    // 3: idle with a full FIFO, redirect to 0x40
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    check_val("t3_valid", instr_valid, 0);
    check_val("t3_req", mem_req, 1);
    check_val("t3_addr", mem_addr, 8'h40);
`ifdef FETCH_STATS_EN
    check_val("t3_flush_cnt", flush_cnt, 1);
    check_val("t3_retired_cnt", retired_cnt, 1);
`endif
    set_mem(1'b1);
    @(negedge clk);
    check_val("t3_pc", instr_pc, 8'h40);
    check_val("t3_instr", instr, mem_fn(8'h40));

    // 4: redirect while the read of 0x05 is pending; its late data is dropped
    do_reset();
    instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 8'h05) found = 1'b1;
      else set_mem(1'b1);
    end
    check_val("t4_reach", found, 1);
    mem_ack        = 1'b0;
    mem_rdata      = 8'h00;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h20;
    @(negedge clk);
    redirect_valid = 1'b0;
    check_val("t4_hold_req", mem_req, 1);
    check_val("t4_hold_addr", mem_addr, 8'h05);
    check_val("t4_flushed", instr_valid, 0);
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 8'hAA;
    @(negedge clk);
    check_val("t4_req", mem_req, 1);
    check_val("t4_addr", mem_addr, 8'h20);
    check_val("t4_no_stale", instr_valid, 0);
    set_mem(1'b1);
    @(negedge clk);
    check_val("t4_valid", instr_valid, 1);
    check_val("t4_pc", instr_pc, 8'h20);
    check_val("t4_instr", instr, mem_fn(8'h20));

    // 5: redirect to 0xFE (with an ack in the same cycle), PC wraps
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFE;
    set_mem(1'b1);
    @(negedge clk);
    redirect_valid = 1'b0;
    check_val("t5_addr", mem_addr, 8'hFE);
    check_val("t5_flushed", instr_valid, 0);
    set_mem(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("t5_valid", instr_valid, 1);
      check_val("t5_pc", instr_pc, 8'(8'hFE + i));
      set_mem(1'b1);
    end

    // 6: reset while REQ is pending with two buffered entries
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_mem(1'b1);
    end
    @(negedge clk);
    check_val("t6_pre_valid", instr_valid, 1);
    check_val("t6_pre_req", mem_req, 1);
    check_val("t6_pre_addr", mem_addr, 8'h02);
    mem_ack = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6");
    reset = 1'b0;
    set_mem(1'b1);
    @(negedge clk);
    check_val("t6_restart_req", mem_req, 1);
    check_val("t6_restart_addr", mem_addr, 8'h00);
    check_val("t6_restart_valid", instr_valid, 0);

    // randomized run against the stream-level model
    do_reset();
    exp_pc       = 8'h00;
    want_target  = 8'h00;
    exp_addr     = 8'h00;
    prev_addr    = 8'h00;
    exp_addr_vld = 1'b0;
    dropping     = 1'b0;
    prev_req     = 1'b0;
    prev_ack     = 1'b0;
    prev_redir   = 1'b0;
    pops         = 0;
    redirs       = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (prev_req && !prev_ack) begin
        check_val("rnd_req_held", mem_req, 1);
        check_val("rnd_addr_stable", mem_addr, prev_addr);
      end
      if (exp_addr_vld) begin
        check_val("rnd_new_req", mem_req, 1);
        check_val("rnd_new_addr", mem_addr, exp_addr);
      end
      if (prev_redir) check_val("rnd_flush", instr_valid, 0);
      if (instr_valid) begin
        check_val("rnd_pc", instr_pc, exp_pc);
        check_val("rnd_instr", instr, mem_fn(instr_pc));
      end else begin
        check_val("rnd_instr_zero", instr, 0);
        check_val("rnd_pc_zero", instr_pc, 0);
      end

      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = !prev_redir && ($urandom_range(0, 19) == 0);
      redirect_pc    = 8'($urandom_range(0, 255));
      set_mem($urandom_range(0, 3) != 0);

      exp_addr_vld = 1'b0;
      nd = redirect_valid ? ((mem_req && !mem_ack) || dropping) : (dropping && !mem_ack);
      if (redirect_valid) begin
        redirs++;
        exp_pc      = redirect_pc;
        want_target = redirect_pc;
        if (!nd) begin
          exp_addr_vld = 1'b1;
          exp_addr     = redirect_pc;
        end
      end else begin
        if (instr_valid && instr_ready) begin
          exp_pc = exp_pc + 8'd1;
          pops++;
        end
        if (dropping && mem_ack) begin
          exp_addr_vld = 1'b1;
          exp_addr     = want_target;
        end
      end
      dropping   = nd;
      prev_req   = mem_req;
      prev_ack   = mem_ack;
      prev_addr  = mem_addr;
      prev_redir = redirect_valid;
    end
    @(negedge clk);
    check_val("rnd_progress", (pops > 200), 1);
`ifdef FETCH_STATS_EN
    check_val("rnd_retired_cnt", retired_cnt, pops);
    check_val("rnd_flush_cnt", flush_cnt, redirs);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
